gpu_rects: RTL and testbench

Multi-rectangle video overlay generator: the parametrised successor to the single-rectangle VGA block. It owns its own horizontal/vertical timing counters and draws up to `NRECT` coloured rectangles with fixed priority. Rectangle geometry is written through a valid/ready port into a shadow bank that commits atomically once per frame, so updates never tear. It sits between the CPU-side control registers and the VGA pins, replacing the one-rectangle `color` output with a `COLOR_W`-bit colour bus.

---
 rtl/gpu_pkg.sv | 38 +++
 rtl/vga_timing.sv | 51 +++++
 rtl/gpu_rects.sv | 151 +++++++++++++++
 tb/tb_gpu_rects.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared display types and default 12 MHz VGA timing for the gpu_* blocks.
package gpu_pkg;

   localparam int POS_W        = 16;
   localparam int RECT_COLOR_W = 16;   // widest colour a channel entry can carry
   localparam int COLOR_W_DEF  = 3;

   localparam int H_VISIBLE_DEF = 320;
   localparam int H_FP_DEF      = 8;
   localparam int H_SYNC_DEF    = 38;
   localparam int H_BP_DEF      = 15;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FP_DEF      = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BP_DEF      = 33;

   typedef struct packed {
      logic                    en;
      logic signed [15:0]      x0;
      logic signed [15:0]      x1;
      logic signed [15:0]      y0;
      logic signed [15:0]      y1;
      logic [RECT_COLOR_W-1:0] color;
   } rect_t;

   localparam rect_t RECT_OFF = '0;

   // Half-open box test; positions are small unsigned counts viewed as signed.
   function automatic logic rect_hit(input rect_t r, input logic [POS_W-1:0] h,
                                     input logic [POS_W-1:0] v);
      logic signed [15:0] hs;
      logic signed [15:0] vs;
      hs = $signed(h);
      vs = $signed(v);
      return r.en && (hs >= r.x0) && (hs < r.x1) && (vs >= r.y0) && (vs < r.y1);
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical counters with raw (undelayed) sync and visible flags.
module vga_timing
   import gpu_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FP      = H_FP_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BP      = H_BP_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FP      = V_FP_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BP      = V_BP_DEF
)(
   input  logic             clk,
   input  logic             reset_n,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             hsync_raw,
   output logic             vsync_raw,
   output logic             visible
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0] H_VIS  = POS_W'(H_VISIBLE);
   localparam logic [POS_W-1:0] V_VIS  = POS_W'(V_VISIBLE);
   localparam logic [POS_W-1:0] HS_BEG = POS_W'(H_VISIBLE + H_FP);
   localparam logic [POS_W-1:0] HS_END = POS_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [POS_W-1:0] VS_BEG = POS_W'(V_VISIBLE + V_FP);
   localparam logic [POS_W-1:0] VS_END = POS_W'(V_VISIBLE + V_FP + V_SYNC);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hpos <= '0;
         vpos <= '0;
      end else if (hpos == H_LAST) begin
         hpos <= '0;
         vpos <= (vpos == V_LAST) ? '0 : vpos + 1'b1;
      end else begin
         hpos <= hpos + 1'b1;
      end
   end

   assign visible   = (hpos < H_VIS) && (vpos < V_VIS);
   assign hsync_raw = !((hpos >= HS_BEG) && (hpos < HS_END));
   assign vsync_raw = !((vpos >= VS_BEG) && (vpos < VS_END));

endmodule

// File: rtl/gpu_rects.sv
// Multi-rectangle overlay: shadow/active geometry banks with per-frame commit,
// hit detection and fixed-priority colour mux, all aligned with the sync outputs.
module gpu_rects
   import gpu_pkg::*;
#(
   parameter int NRECT     = 4,
   parameter int COLOR_W   = COLOR_W_DEF,
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FP      = H_FP_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BP      = H_BP_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FP      = V_FP_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BP      = V_BP_DEF,
   localparam int IDX_W    = (NRECT > 1) ? $clog2(NRECT) : 1
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic               wr_en,
   input  logic signed [15:0] wr_x0,
   input  logic signed [15:0] wr_x1,
   input  logic signed [15:0] wr_y0,
   input  logic signed [15:0] wr_y1,
   input  logic [COLOR_W-1:0] wr_color,
   output logic               hsync,
   output logic               vsync,
   output logic [COLOR_W-1:0] color,
   output logic [15:0]        frame,
   output logic               frame_tick
);

   logic [POS_W-1:0] hpos_p0;
   logic [POS_W-1:0] vpos_p0;
   logic             hs_p0;
   logic             vs_p0;
   logic             vld_p0;
   logic             commit_p0;
   logic             wr_fire;
   rect_t            wr_rect;
   rect_t            shadow [NRECT];
   rect_t            active [NRECT];

   logic [NRECT-1:0]   hit_p1;
   logic               vld_p1;
   logic               hs_p1;
   logic               vs_p1;
   logic [COLOR_W-1:0] mux_p1;

   // ---- stage 0: timing counters, write port, commit ----
   vga_timing #(
      .H_VISIBLE (H_VISIBLE),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_VISIBLE (V_VISIBLE),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP)
   ) u_timing (
      .clk       (clk),
      .reset_n   (reset_n),
      .hpos      (hpos_p0),
      .vpos      (vpos_p0),
      .hsync_raw (hs_p0),
      .vsync_raw (vs_p0),
      .visible   (vld_p0)
   );

   assign commit_p0 = (hpos_p0 == '0) && (vpos_p0 == POS_W'(V_VISIBLE));
   // Holding writes off the commit cycle keeps the shadow stable while it is copied.
   assign wr_ready  = !commit_p0;
   assign wr_fire   = wr_valid && wr_ready && (int'(wr_idx) < NRECT);

   always_comb begin
      wr_rect       = RECT_OFF;
      wr_rect.en    = wr_en;
      wr_rect.x0    = wr_x0;
      wr_rect.x1    = wr_x1;
      wr_rect.y0    = wr_y0;
      wr_rect.y1    = wr_y1;
      wr_rect.color = RECT_COLOR_W'(wr_color);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NRECT; i++) begin
            shadow[i] <= RECT_OFF;
            active[i] <= RECT_OFF;
         end
      end else begin
         if (wr_fire)
            shadow[wr_idx] <= wr_rect;
         if (commit_p0)
            for (int i = 0; i < NRECT; i++)
               active[i] <= shadow[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame      <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= commit_p0;
         if (commit_p0)
            frame <= frame + 16'd1;
      end
   end

   // ---- stage 1: per-channel hit vector, visible flag, sync delay ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_p1 <= '0;
         vld_p1 <= 1'b0;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
      end else begin
         for (int i = 0; i < NRECT; i++)
            hit_p1[i] <= rect_hit(active[i], hpos_p0, vpos_p0);
         vld_p1 <= vld_p0;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
      end
   end

   // Commits land in vertical blanking, so reading active here matches the hits.
   always_comb begin
      mux_p1 = '0;
      for (int i = NRECT - 1; i >= 0; i--)
         if (hit_p1[i])
            mux_p1 = active[i].color[COLOR_W-1:0];
   end

   // ---- stage 2: output pins ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         color <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         color <= vld_p1 ? mux_p1 : '0;
         hsync <= hs_p1;
         vsync <= vs_p1;
      end
   end

endmodule

// File: tb/tb_gpu_rects.sv
// Scoreboard bench for gpu_rects on a shrunken 23x17 raster (16x12 visible).
module tb_gpu_rects;

   localparam int HT    = 23;
   localparam int VT    = 17;
   localparam int FRAME = HT * VT;          // 391 clocks
   localparam int NC    = 12 * HT;          // commit offset within a frame

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               wr_valid = 1'b0;
   logic               wr_ready;
   logic [1:0]         wr_idx = '0;
   logic               wr_en = 1'b0;
   logic signed [15:0] wr_x0 = '0;
   logic signed [15:0] wr_x1 = '0;
   logic signed [15:0] wr_y0 = '0;
   logic signed [15:0] wr_y1 = '0;
   logic [2:0]         wr_color = '0;
   logic               hsync;
   logic               vsync;
   logic [2:0]         color;
   logic [15:0]        frame;
   logic               frame_tick;

   gpu_rects #(
      .NRECT(3), .COLOR_W(3),
      .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(12), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_en(wr_en),
      .wr_x0(wr_x0), .wr_x1(wr_x1), .wr_y0(wr_y0), .wr_y1(wr_y1), .wr_color(wr_color),
      .hsync(hsync), .vsync(vsync), .color(color), .frame(frame), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pix;

   typedef struct { int n; int kind; int val; } exp_t;
   exp_t sb[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   function automatic string kname(input int k);
      return (k == 0) ? "color" : (k == 1) ? "hsync" : "vsync";
   endfunction

   // kind 0 = color, 1 = hsync, 2 = vsync; f counts frames since reset release
   task automatic push(input int f, input int x, input int y, input int kind, input int val);
      exp_t e;
      int   i;
      e.n = f * FRAME + y * HT + x;
      e.kind = kind;
      e.val = val;
      i = 0;
      while (i < sb.size() && sb[i].n <= e.n) i++;
      sb.insert(i, e);
   endtask

   // Edges since release: the pins after edge p show the counter value p-2.
   always @(posedge clk or negedge reset_n)
      if (!reset_n) pix <= 0;
      else          pix <= pix + 1;

   exp_t mon_e;
   int   mon_act;
   always @(negedge clk) begin
      if (reset_n) begin
         while (sb.size() > 0 && sb[0].n <= pix - 2) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
               0:       mon_act = int'(color);
               1:       mon_act = int'(hsync);
               default: mon_act = int'(vsync);
            endcase
            if (mon_e.n != pix - 2) mon_act = -1;
            chk($sformatf("%s f%0d x%0d y%0d", kname(mon_e.kind), mon_e.n / FRAME,
                          (mon_e.n % FRAME) % HT, (mon_e.n % FRAME) / HT), mon_act, mon_e.val);
         end
      end
   end

   int tick_last;
   always @(negedge clk) begin
      if (!reset_n) tick_last = -1;
      else if (frame_tick) begin
         if (tick_last >= 0) chk("tick_gap", pix - tick_last, FRAME);
         tick_last = pix;
      end
   end

   task automatic wait_pix(input int n);
      int guard;
      guard = 0;
      while (pix != n && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (pix != n) chk("wait_pix", pix, n);
   endtask

   task automatic do_write(input int idx, input int en, input int x0, input int x1,
                           input int y0, input int y1, input int c, output int tries);
      logic ok;
      wr_idx   = 2'(idx);
      wr_en    = (en != 0);
      wr_x0    = 16'(x0);
      wr_x1    = 16'(x1);
      wr_y0    = 16'(y0);
      wr_y1    = 16'(y1);
      wr_color = 3'(c);
      wr_valid = 1'b1;
      tries = 0;
      do begin
         ok = wr_ready;
         @(posedge clk); #1;
         tries++;
      end while (!ok && tries < 4);
      wr_valid = 1'b0;
   endtask

   initial begin
      int t;
      int guard;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_color", int'(color), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_frame", int'(frame), 0);
      chk("rst_tick", int'(frame_tick), 0);
      chk("rst_ready", int'(wr_ready), 1);

      // Frame 0: sync edges, nothing drawn yet
      push(0, 17, 0, 1, 1); push(0, 18, 0, 1, 0); push(0, 20, 0, 1, 0); push(0, 21, 0, 1, 1);
      push(0, 0, 12, 2, 1); push(0, 0, 13, 2, 0); push(0, 22, 14, 2, 0); push(0, 0, 15, 2, 1);
      push(0, 0, 0, 0, 0);  push(0, 10, 5, 0, 0);
      // Frame 1: single box (10,14,5,8) colour 5
      push(1, 9, 5, 0, 0);  push(1, 10, 5, 0, 5); push(1, 13, 5, 0, 5); push(1, 14, 5, 0, 0);
      push(1, 10, 4, 0, 0); push(1, 10, 7, 0, 5); push(1, 13, 7, 0, 5); push(1, 10, 8, 0, 0);
      // Frame 2: full-screen idx1 colour 2 under small idx0 box colour 7
      push(2, 0, 0, 0, 2);  push(2, 5, 5, 0, 7);  push(2, 6, 6, 0, 7);  push(2, 7, 5, 0, 2);
      push(2, 4, 5, 0, 2);  push(2, 5, 7, 0, 2);  push(2, 15, 11, 0, 2); push(2, 16, 0, 0, 0);
      push(2, 0, 12, 0, 0); push(2, 22, 11, 0, 0);
      // Frame 3: negative box hits x0..2 on line 0 only; zero-width box never hits
      push(3, 0, 0, 0, 1);  push(3, 2, 0, 0, 1);  push(3, 3, 0, 0, 0);  push(3, 0, 1, 0, 0);
      push(3, 8, 0, 0, 0);  push(3, 8, 5, 0, 0);  push(3, 5, 5, 0, 0);  push(3, 15, 11, 0, 0);
      // Frame 4: write held at commit not yet visible
      push(4, 10, 5, 0, 0); push(4, 0, 0, 0, 1);
      // Frame 5: held write and pre-commit write both visible
      push(5, 10, 5, 0, 6); push(5, 0, 0, 0, 1);  push(5, 0, 6, 0, 3);  push(5, 1, 6, 0, 3);
      push(5, 2, 6, 0, 6);  push(5, 0, 8, 0, 6);

      @(negedge clk);
      reset_n = 1'b1;

      wait_pix(3);
      do_write(0, 1, 10, 14, 5, 8, 5, t);

      wait_pix(NC);
      chk("ready_commit0", int'(wr_ready), 0);
      chk("frame_pre0", int'(frame), 0);
      chk("tick_pre0", int'(frame_tick), 0);
      wait_pix(NC + 1);
      chk("frame_post0", int'(frame), 1);
      chk("tick_post0", int'(frame_tick), 1);
      chk("ready_after0", int'(wr_ready), 1);
      wait_pix(NC + 2);
      chk("tick_end0", int'(frame_tick), 0);

      wait_pix(FRAME + 10);
      do_write(1, 1, 0, 16, 0, 12, 2, t);
      do_write(0, 1, 5, 7, 5, 7, 7, t);
      wait_pix(FRAME + NC + 1);
      chk("frame_post1", int'(frame), 2);
      chk("tick_post1", int'(frame_tick), 1);

      wait_pix(2 * FRAME + 10);
      do_write(0, 1, 0, 16, 0, 12, 4, t);
      do_write(3, 1, 0, 16, 0, 12, 6, t);      // index beyond NRECT: dropped
      do_write(0, 1, -5, 3, -5, 1, 1, t);
      do_write(1, 1, 8, 8, 0, 12, 3, t);

      wait_pix(3 * FRAME + NC);
      chk("ready_commit3", int'(wr_ready), 0);
      do_write(2, 1, 0, 16, 0, 12, 6, t);
      chk("commit_hold_cycles", t, 2);

      wait_pix(4 * FRAME + NC - 1);
      chk("ready_precommit4", int'(wr_ready), 1);
      do_write(1, 1, 0, 2, 6, 7, 3, t);
      chk("precommit_cycles", t, 1);
      chk("frame_at4", int'(frame), 4);

      // Mid-frame reset on line 8 of frame 5, after pixel (0,8) has shown colour 6
      wait_pix(5 * FRAME + 8 * HT + 2);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_color", int'(color), 0);
      chk("mid_hsync", int'(hsync), 1);
      chk("mid_vsync", int'(vsync), 1);
      chk("mid_frame", int'(frame), 0);
      chk("mid_ready", int'(wr_ready), 1);
      chk("sb_drained_pre_reset", sb.size(), 0);
      sb.delete();
      repeat (2) @(posedge clk);

      // Banks cleared: full-screen idx2 colour 6 must be gone
      push(0, 0, 0, 0, 0); push(0, 5, 3, 0, 0); push(0, 17, 0, 1, 1); push(0, 18, 0, 1, 0);
      push(1, 5, 3, 0, 0); push(1, 10, 5, 0, 0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;

      wait_pix(NC);
      chk("frame_restart", int'(frame), 0);
      wait_pix(NC + 1);
      chk("frame_resume", int'(frame), 1);
      chk("tick_resume", int'(frame_tick), 1);

      guard = 0;
      while (sb.size() > 0 && guard < 2 * FRAME) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("sb_leftover", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
